// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions for the program loader: bus widths,
// the frame start marker and the loader FSM state encoding.
package arch_defs_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        L_IDLE   = 3'd0,
        L_ADDR_H = 3'd1,
        L_ADDR_L = 3'd2,
        L_LEN_H  = 3'd3,
        L_LEN_L  = 3'd4,
        L_DATA   = 3'd5,
        L_CSUM   = 3'd6
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Serial program loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from a byte
// stream, writes the payload into RAM and releases the CPU on a good frame.
module program_loader
    import arch_defs_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = LOADER_SYNC_BYTE,
    parameter bit                    HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    loader_state_t         state;
    loader_state_t         next_state;

    logic [ADDR_WIDTH-1:0] ptr;        // next RAM write address
    logic [ADDR_WIDTH-1:0] remaining;  // holds LEN_H in [15:8] until LEN_L arrives
    logic [DATA_WIDTH-1:0] csum;       // running mod-256 sum since ADDR_H

    logic                  accept;
    logic [DATA_WIDTH-1:0] csum_next;
    logic [ADDR_WIDTH-1:0] frame_len;
    logic                  sync_fire;
    logic                  write_fire;
    logic                  good_fire;
    logic                  bad_fire;

    assign accept    = rx_valid && rx_ready;
    assign csum_next = csum + rx_data;
    assign frame_len = {remaining[ADDR_WIDTH-1:DATA_WIDTH], rx_data};
    assign busy      = (state != L_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= L_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-byte event strobes.
    always_comb begin
        next_state = state;
        sync_fire  = 1'b0;
        write_fire = 1'b0;
        good_fire  = 1'b0;
        bad_fire   = 1'b0;
        if (accept) begin
            unique case (state)
                L_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        sync_fire  = 1'b1;
                        next_state = L_ADDR_H;
                    end
                end
                L_ADDR_H: next_state = L_ADDR_L;
                L_ADDR_L: next_state = L_LEN_H;
                L_LEN_H:  next_state = L_LEN_L;
                L_LEN_L:  next_state = (frame_len == '0) ? L_CSUM : L_DATA;
                L_DATA: begin
                    write_fire = 1'b1;
                    if (remaining == ADDR_WIDTH'(1)) begin
                        next_state = L_CSUM;
                    end
                end
                L_CSUM: begin
                    good_fire  = (csum_next == '0);
                    bad_fire   = (csum_next != '0);
                    next_state = L_IDLE;
                end
                default: next_state = L_IDLE;
            endcase
        end
    end

    // No backpressure: ready rises on the first clock out of reset and stays.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ready <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
        end
    end

    // Frame bookkeeping: address pointer, remaining count and checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            remaining <= '0;
            csum      <= '0;
        end else if (accept) begin
            if (sync_fire) begin
                csum <= '0;
            end else if (state != L_IDLE) begin
                csum <= csum_next;
            end
            unique case (state)
                L_ADDR_H: ptr[ADDR_WIDTH-1:DATA_WIDTH]       <= rx_data;
                L_ADDR_L: ptr[DATA_WIDTH-1:0]                <= rx_data;
                L_LEN_H:  remaining[ADDR_WIDTH-1:DATA_WIDTH] <= rx_data;
                L_LEN_L:  remaining                          <= frame_len;
                L_DATA: begin
                    ptr       <= ptr + 1'b1;   // natural wrap FFFF -> 0000
                    remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered RAM write port and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= HOLD_AT_RESET;
        end else begin
            mem_we <= write_fire;
            done   <= good_fire;
            if (write_fire) begin
                mem_addr  <= ptr;
                mem_wdata <= rx_data;
            end
            if (sync_fire) begin
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (good_fire) begin
                cpu_hold <= 1'b0;
            end else if (bad_fire) begin
                err <= 1'b1;
            end
        end
    end

endmodule
